// File: rtl/gpu_bg_line_buffer_if.sv
// Handshake bundle between the GPU micro-op executor, the background line buffer
// and the LCD pixel consumer.
interface gpu_bg_line_buffer_if;
  logic       iWrite;
  logic [7:0] iBh;
  logic [7:0] iBl;
  logic [2:0] iScxFine;
  logic [7:0] iBgp;
  logic       oWriteReady;
  logic [1:0] oPixel;
  logic       oPixelValid;
  logic       iPixelReady;
  logic       oLineDone;

  modport master (
    output iWrite,
    output iBh,
    output iBl,
    output iScxFine,
    output iBgp,
    output iPixelReady,
    input  oWriteReady,
    input  oPixel,
    input  oPixelValid,
    input  oLineDone
  );

  modport slave (
    input  iWrite,
    input  iBh,
    input  iBl,
    input  iScxFine,
    input  iBgp,
    input  iPixelReady,
    output oWriteReady,
    output oPixel,
    output oPixelValid,
    output oLineDone
  );
endinterface

// File: rtl/gpu_bg_line_buffer.sv
// Double-buffered background scanline buffer: captures 32 tile-row byte pairs per line and
// streams 160 palette-mapped shades with SCX fine scroll over a valid/ready handshake.
module gpu_bg_line_buffer #(
  parameter int unsigned TILES_PER_LINE  = 32,
  parameter int unsigned PIXELS_PER_LINE = 160
) (
  input logic                  iClock,
  input logic                  iReset,
  gpu_bg_line_buffer_if.slave  bus
);

  localparam int unsigned PtrW  = $clog2(TILES_PER_LINE);
  localparam int unsigned PcntW = $clog2(PIXELS_PER_LINE);
  localparam logic [PtrW-1:0]  LastPtr = PtrW'(TILES_PER_LINE - 1);
  localparam logic [PcntW-1:0] LastPix = PcntW'(PIXELS_PER_LINE - 1);

  typedef enum logic [1:0] {StIdle, StSkip, StOut} state_e;

  logic [15:0]      mem_q [2][TILES_PER_LINE];
  logic [1:0]       full_q, full_d;
  logic             wbank_q, wbank_d;
  logic             rbank_q, rbank_d;
  logic [PtrW-1:0]  wptr_q, wptr_d;
  state_e           state_q, state_d;
  logic [2:0]       skip_q, skip_d;
  logic [2:0]       bit_q, bit_d;
  logic [PtrW-1:0]  tile_q, tile_d;
  logic [PcntW-1:0] pcnt_q, pcnt_d;
  logic [1:0]       pixel_q, pixel_d;
  logic             valid_q, valid_d;
  logic             done_q, done_d;

  logic             write_fire;
  logic             handshake;
  logic [2:0]       nxt_bit;
  logic [PtrW-1:0]  nxt_tile;
  logic [2:0]       ld_bit;
  logic [PtrW-1:0]  ld_tile;
  logic [15:0]      ld_entry;
  logic [1:0]       ld_idx;
  logic [1:0]       ld_shade;

  assign bus.oWriteReady = !full_q[wbank_q];
  assign bus.oPixel      = pixel_q;
  assign bus.oPixelValid = valid_q;
  assign bus.oLineDone   = done_q;

  assign write_fire = bus.iWrite && bus.oWriteReady;
  assign handshake  = valid_q && bus.iPixelReady;

  assign nxt_bit  = bit_q + 3'd1;
  assign nxt_tile = (bit_q == 3'd7) ? tile_q + PtrW'(1) : tile_q;

  // In OUT the register is refilled with the position after the one being consumed;
  // in SKIP the first pixel comes from the current position.
  assign ld_tile  = (state_q == StOut) ? nxt_tile : tile_q;
  assign ld_bit   = (state_q == StOut) ? nxt_bit : bit_q;
  assign ld_entry = mem_q[rbank_q][ld_tile];
  // Entry is {bh,bl}; bit 0 of the scan maps to bitplane bit 7.
  assign ld_idx   = {ld_entry[{1'b1, ~ld_bit}], ld_entry[{1'b0, ~ld_bit}]};
  assign ld_shade = {bus.iBgp[{ld_idx, 1'b1}], bus.iBgp[{ld_idx, 1'b0}]};

  always_comb begin
    full_d  = full_q;
    wbank_d = wbank_q;
    rbank_d = rbank_q;
    wptr_d  = wptr_q;
    state_d = state_q;
    skip_d  = skip_q;
    bit_d   = bit_q;
    tile_d  = tile_q;
    pcnt_d  = pcnt_q;
    pixel_d = pixel_q;
    valid_d = valid_q;
    done_d  = 1'b0;

    if (write_fire) begin
      if (wptr_q == LastPtr) begin
        wptr_d          = '0;
        full_d[wbank_q] = 1'b1;
        wbank_d         = ~wbank_q;
      end else begin
        wptr_d = wptr_q + PtrW'(1);
      end
    end

    unique case (state_q)
      StIdle: begin
        if (full_q[rbank_q]) begin
          skip_d  = bus.iScxFine;
          tile_d  = '0;
          bit_d   = '0;
          pcnt_d  = '0;
          state_d = StSkip;
        end
      end
      StSkip: begin
        if (skip_q != 3'd0) begin
          skip_d = skip_q - 3'd1;
          bit_d  = nxt_bit;
        end else begin
          pixel_d = ld_shade;
          valid_d = 1'b1;
          state_d = StOut;
        end
      end
      StOut: begin
        if (handshake) begin
          if (pcnt_q == LastPix) begin
            valid_d         = 1'b0;
            done_d          = 1'b1;
            full_d[rbank_q] = 1'b0;
            rbank_d         = ~rbank_q;
            state_d         = StIdle;
          end else begin
            pcnt_d  = pcnt_q + PcntW'(1);
            bit_d   = nxt_bit;
            tile_d  = nxt_tile;
            pixel_d = ld_shade;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge iClock) begin
    if (iReset) begin
      full_q  <= '0;
      wbank_q <= 1'b0;
      rbank_q <= 1'b0;
      wptr_q  <= '0;
      state_q <= StIdle;
      skip_q  <= '0;
      bit_q   <= '0;
      tile_q  <= '0;
      pcnt_q  <= '0;
      pixel_q <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      full_q  <= full_d;
      wbank_q <= wbank_d;
      rbank_q <= rbank_d;
      wptr_q  <= wptr_d;
      state_q <= state_d;
      skip_q  <= skip_d;
      bit_q   <= bit_d;
      tile_q  <= tile_d;
      pcnt_q  <= pcnt_d;
      pixel_q <= pixel_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  // Storage needs no reset: the full flags gate every read.
  always_ff @(posedge iClock) begin
    if (!iReset && write_fire) begin
      mem_q[wbank_q][wptr_q] <= {bus.iBh, bus.iBl};
    end
  end

endmodule

// File: tb/tb_gpu_bg_line_buffer.sv
// Directed bench for gpu_bg_line_buffer: fills lines, drains them and compares each
// shade against values derived from the tile bytes, scroll and palette.
module tb_gpu_bg_line_buffer;

  logic iClock = 1'b0;
  logic iReset;

  always #5 iClock = ~iClock;

  gpu_bg_line_buffer_if bus ();

  gpu_bg_line_buffer #(
    .TILES_PER_LINE (32),
    .PIXELS_PER_LINE(160)
  ) dut (
    .iClock(iClock),
    .iReset(iReset),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]  line_bh [2][32];
  logic [7:0]  line_bl [2][32];
  logic [1:0]  got     [160];
  logic [1:0]  got_ref [160];
  logic [15:0] lfsr = 16'hACE1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge iClock);
    #1;
  endtask

  function automatic logic [1:0] model_px(input int slot, input int fine, input logic [7:0] bgp,
                                          input int p);
    int pos, t, b, idx;
    logic [7:0] sh;
    pos = p + fine;
    t   = pos / 8;
    b   = pos % 8;
    idx = 2 * int'(line_bh[slot][t][7-b]) + int'(line_bl[slot][t][7-b]);
    sh  = bgp >> (2 * idx);
    return sh[1:0];
  endfunction

  task automatic write_line(input int slot, input string tag);
    int nbad = 0;
    for (int i = 0; i < 32; i++) begin
      if (bus.oWriteReady !== 1'b1) nbad++;
      bus.iWrite = 1'b1;
      bus.iBh    = line_bh[slot][i];
      bus.iBl    = line_bl[slot][i];
      step();
    end
    bus.iWrite = 1'b0;
    check(tag, nbad, 0);
  endtask

  task automatic wait_valid(input int exp_lat, input string tag);
    int n = 0;
    while (bus.oPixelValid !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    check(tag, n, exp_lat);
  endtask

  task automatic drain(input int slot, input int fine, input logic [7:0] bgp, input bit rnd,
                       input int stop_at, input string tag);
    int p = 0, cyc = 0, nbad = 0, nstab = 0, ndone = 0;
    logic r, held;
    logic [1:0] hp;
    held = 1'b0;
    hp   = 2'd0;
    while (p < stop_at && cyc < 3000) begin
      r = 1'b1;
      if (rnd) begin
        lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        r    = lfsr[0];
      end
      bus.iPixelReady = r;
      if (held && (bus.oPixelValid !== 1'b1 || bus.oPixel !== hp)) nstab++;
      held = 1'b0;
      if (bus.oLineDone === 1'b1) ndone++;
      if (bus.oPixelValid === 1'b1) begin
        if (r) begin
          got[p] = bus.oPixel;
          p++;
        end else begin
          held = 1'b1;
          hp   = bus.oPixel;
        end
      end
      step();
      cyc++;
    end
    check({tag, "_count"}, p, stop_at);
    for (int i = 0; i < p; i++) begin
      if (got[i] !== model_px(slot, fine, bgp, i)) nbad++;
    end
    check({tag, "_pixels"}, nbad, 0);
    check({tag, "_early_done"}, ndone, 0);
    if (rnd) check({tag, "_stable"}, nstab, 0);
    if (stop_at == 160) begin
      check({tag, "_done"}, bus.oLineDone, 1);
      check({tag, "_valid_off"}, bus.oPixelValid, 0);
    end
  endtask

  initial begin
    int nchg;
    logic [1:0] hp;

    iReset          = 1'b1;
    bus.iWrite      = 1'b0;
    bus.iBh         = 8'h00;
    bus.iBl         = 8'h00;
    bus.iScxFine    = 3'd0;
    bus.iBgp        = 8'hE4;
    bus.iPixelReady = 1'b0;
    step();
    step();
    check("rst_pixel", bus.oPixel, 0);
    check("rst_valid", bus.oPixelValid, 0);
    check("rst_done", bus.oLineDone, 0);
    check("rst_wready", bus.oWriteReady, 1);
    iReset = 1'b0;
    step();

    // Solid shade 2, no scroll.
    for (int i = 0; i < 32; i++) begin
      line_bh[0][i] = 8'hFF;
      line_bl[0][i] = 8'h00;
    end
    bus.iPixelReady = 1'b1;
    write_line(0, "t1_wr");
    wait_valid(2, "t1_latency");
    drain(0, 0, 8'hE4, 1'b0, 160, "t1");
    check("t1_px0", got[0], 2);
    check("t1_px159", got[159], 2);
    step();
    check("t1_done_pulse", bus.oLineDone, 0);
    repeat (5) step();
    check("t1_idle_valid", bus.oPixelValid, 0);
    check("t1_idle_wready", bus.oWriteReady, 1);

    // Fine scroll 3 skips bits 0..2 of tile 0.
    for (int i = 0; i < 32; i++) begin
      line_bh[0][i] = 8'h00;
      line_bl[0][i] = 8'h00;
    end
    line_bh[0][0] = 8'h0F;
    line_bl[0][0] = 8'h33;
    bus.iScxFine = 3'd3;
    write_line(0, "t2_wr");
    wait_valid(5, "t2_latency");
    drain(0, 3, 8'hE4, 1'b0, 160, "t2");
    check("t2_px0", got[0], 1);
    check("t2_px1", got[1], 2);
    check("t2_px2", got[2], 2);
    check("t2_px3", got[3], 3);
    check("t2_px4", got[4], 3);
    check("t2_px5", got[5], 0);
    step();

    // Backpressure: same line with ready=1, then with pseudo-random ready.
    for (int i = 0; i < 32; i++) begin
      line_bh[0][i] = 8'(i * 8 + 3);
      line_bl[0][i] = 8'(i * 5);
    end
    bus.iScxFine = 3'd1;
    write_line(0, "t3a_wr");
    wait_valid(3, "t3a_latency");
    drain(0, 1, 8'hE4, 1'b0, 160, "t3a");
    for (int i = 0; i < 160; i++) got_ref[i] = got[i];
    step();
    write_line(0, "t3b_wr");
    wait_valid(3, "t3b_latency");
    drain(0, 1, 8'hE4, 1'b1, 160, "t3b");
    nchg = 0;
    for (int i = 0; i < 160; i++) if (got[i] !== got_ref[i]) nchg++;
    check("t3_same_as_ready1", nchg, 0);
    step();

    // Double buffer with the consumer stalled.
    for (int i = 0; i < 32; i++) begin
      line_bh[0][i] = 8'(i);
      line_bl[0][i] = 8'hF0 ^ 8'(i);
      line_bh[1][i] = 8'(i * 3) ^ 8'hFF;
      line_bl[1][i] = 8'(i * 9);
    end
    bus.iScxFine    = 3'd2;
    bus.iPixelReady = 1'b0;
    write_line(0, "t4_wr0");
    write_line(1, "t4_wr1");
    check("t4_wready_full", bus.oWriteReady, 0);
    bus.iWrite = 1'b1;
    bus.iBh    = 8'h12;
    bus.iBl    = 8'h34;
    step();
    bus.iWrite = 1'b0;
    check("t4_valid_held", bus.oPixelValid, 1);
    hp       = bus.oPixel;
    bus.iBgp = 8'h1B;
    nchg     = 0;
    repeat (3) begin
      step();
      if (bus.oPixel !== hp || bus.oPixelValid !== 1'b1) nchg++;
    end
    check("t4_bgp_hold", nchg, 0);
    bus.iBgp = 8'hE4;
    drain(0, 2, 8'hE4, 1'b0, 160, "t4a");
    check("t4_wready_freed", bus.oWriteReady, 1);
    step();
    check("t4a_done_pulse", bus.oLineDone, 0);
    drain(1, 2, 8'hE4, 1'b0, 160, "t4b");
    step();

    // Palette remap through 1B.
    for (int i = 0; i < 32; i++) begin
      line_bh[0][i] = 8'hAA;
      line_bl[0][i] = 8'h55;
    end
    bus.iScxFine = 3'd0;
    bus.iBgp     = 8'h1B;
    write_line(0, "t5_wr");
    wait_valid(2, "t5_latency");
    drain(0, 0, 8'h1B, 1'b0, 160, "t5");
    check("t5_px0", got[0], 1);
    check("t5_px1", got[1], 2);
    check("t5_px158", got[158], 1);
    check("t5_px159", got[159], 2);
    step();

    // Reset mid-line, then mid-fill, then a clean line.
    bus.iBgp = 8'hE4;
    for (int i = 0; i < 32; i++) begin
      line_bh[0][i] = 8'(i) ^ 8'h5A;
      line_bl[0][i] = 8'(i * 3);
      line_bh[1][i] = 8'(i * 7 + 1);
      line_bl[1][i] = ~8'(i);
    end
    bus.iScxFine = 3'd4;
    write_line(0, "t6a_wr");
    wait_valid(6, "t6a_latency");
    drain(0, 4, 8'hE4, 1'b0, 80, "t6a");
    iReset = 1'b1;
    step();
    check("t6_rst_pixel", bus.oPixel, 0);
    check("t6_rst_valid", bus.oPixelValid, 0);
    check("t6_rst_done", bus.oLineDone, 0);
    check("t6_rst_wready", bus.oWriteReady, 1);
    iReset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus.iWrite = 1'b1;
      bus.iBh    = 8'hC3;
      bus.iBl    = 8'h3C;
      step();
    end
    bus.iWrite = 1'b0;
    iReset     = 1'b1;
    step();
    iReset = 1'b0;
    check("t6_fill_rst_wready", bus.oWriteReady, 1);
    check("t6_fill_rst_valid", bus.oPixelValid, 0);
    bus.iScxFine = 3'd0;
    write_line(1, "t6b_wr");
    wait_valid(2, "t6b_latency");
    drain(1, 0, 8'hE4, 1'b0, 160, "t6b");
    step();
    check("t6b_done_pulse", bus.oLineDone, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
